disparity_vga_out: RTL and testbench

- Downstream display stage for the disparity engine.
- Generates 640x480@60 VGA timing from a pixel-enable strobe and sweeps the disparity readback address (disp_href/disp_vref).
- Upscales each disparity pixel to a SCALE x SCALE square, maps the 8-bit disparity index to 3-3-2 grayscale, and drives the Nexys3 VGA connector.
- Shows the map only on frames that start while the disparity engine is idle; otherwise the image area is black.

---
 rtl/disparity_vga_out_if.sv | 25 ++
 rtl/disparity_vga_out.sv | 166 ++++++++++++++++
 tb/tb_disparity_vga_out.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/disparity_vga_out_if.sv
// Bus between the disparity display stage and its surroundings: pixel strobe,
// disparity readback port and the VGA connector pins.
interface disparity_vga_out_if;
  logic       pix_en;
  logic       disp_idle;
  logic [7:0] disp_data;
  logic [9:0] disp_href;
  logic [9:0] disp_vref;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;
  logic       frame_start;

  // Environment side: supplies strobe, idle flag and readback data.
  modport master (
    output pix_en, disp_idle, disp_data,
    input  disp_href, disp_vref, hsync, vsync, rgb, frame_start
  );

  // Display stage side.
  modport slave (
    input  pix_en, disp_idle, disp_data,
    output disp_href, disp_vref, hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/disparity_vga_out.sv
// Disparity display stage: VGA timing, disparity readback sweep, SCALE x SCALE
// upscaling and 3-3-2 grayscale mapping. The map is shown only on frames that
// begin while the disparity engine is idle, so a frame never tears.
module disparity_vga_out #(
  parameter int IMG_W    = 20,
  parameter int IMG_H    = 7,
  parameter int SCALE    = 16,
  parameter int GAIN     = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                i_clk,
  input  logic                i_reset,
  disparity_vga_out_if.slave  io_bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  IMG_X    = 10'(IMG_W * SCALE);
  localparam logic [9:0]  IMG_Y    = 10'(IMG_H * SCALE);
  localparam logic [9:0]  SUB_LAST = 10'(SCALE - 1);
  localparam logic [9:0]  HREF_MAX = 10'(IMG_W - 1);
  localparam logic [9:0]  VREF_MAX = 10'(IMG_H - 1);
  localparam logic [15:0] GAIN_W   = 16'(GAIN);

  // Disparity index -> saturated intensity -> {R,G,B} = 3-3-2 gray.
  function automatic logic [7:0] gray332(input logic [7:0] d);
    logic [15:0] prod;
    logic [7:0]  v;
    prod = {8'h00, d} * GAIN_W;
    if (prod > 16'd255) begin
      v = 8'hFF;
    end else begin
      v = prod[7:0];
    end
    return {v[7:5], v[7:5], v[7:6]};
  endfunction

  logic [9:0] r_h_cnt, r_v_cnt;
  logic [9:0] r_sx, r_sy;
  logic [9:0] r_href, r_vref;
  logic       r_hsync, r_vsync;
  logic [7:0] r_rgb;
  logic       r_frame_start, r_frame_valid;

  logic       w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_in_img;
  logic       w_hsync_raw, w_vsync_raw;
  logic [7:0] w_pix;

  assign w_h_wrap    = (r_h_cnt == H_LAST);
  assign w_v_wrap    = (r_v_cnt == V_LAST);
  assign w_h_act     = (r_h_cnt < H_ACT);
  assign w_v_act     = (r_v_cnt < V_ACT);
  assign w_in_img    = w_h_act && w_v_act && (r_h_cnt < IMG_X) && (r_v_cnt < IMG_Y);
  assign w_hsync_raw = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vsync_raw = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
  assign w_pix       = (w_in_img && r_frame_valid) ? gray332(io_bus.disp_data) : 8'h00;

  // Screen position: h_cnt sweeps a line, v_cnt steps once per line wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (io_bus.pix_en) begin
      if (w_h_wrap) begin
        r_h_cnt <= 10'd0;
        r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Column address: one step per SCALE active pixels, saturating; held in blanking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sx   <= 10'd0;
      r_href <= 10'd0;
    end else if (io_bus.pix_en) begin
      if (w_h_wrap) begin
        r_sx   <= 10'd0;
        r_href <= 10'd0;
      end else if (w_h_act) begin
        if (r_sx == SUB_LAST) begin
          r_sx <= 10'd0;
          if (r_href != HREF_MAX) begin
            r_href <= r_href + 10'd1;
          end
        end else begin
          r_sx <= r_sx + 10'd1;
        end
      end
    end
  end

  // Row address: one step per SCALE active lines, saturating; cleared per frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sy   <= 10'd0;
      r_vref <= 10'd0;
    end else if (io_bus.pix_en && w_h_wrap) begin
      if (w_v_wrap) begin
        r_sy   <= 10'd0;
        r_vref <= 10'd0;
      end else if (w_v_act) begin
        if (r_sy == SUB_LAST) begin
          r_sy <= 10'd0;
          if (r_vref != VREF_MAX) begin
            r_vref <= r_vref + 10'd1;
          end
        end else begin
          r_sy <= r_sy + 10'd1;
        end
      end
    end
  end

  // Frame gate: disp_idle is latched only as the counters move to (0,0).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_start <= 1'b0;
      r_frame_valid <= 1'b0;
    end else if (io_bus.pix_en && w_h_wrap && w_v_wrap) begin
      r_frame_start <= 1'b1;
      r_frame_valid <= io_bus.disp_idle;
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  // Pin stage: colour and syncs share one register so they stay aligned.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rgb   <= 8'h00;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (io_bus.pix_en) begin
      r_rgb   <= w_pix;
      r_hsync <= w_hsync_raw;
      r_vsync <= w_vsync_raw;
    end
  end

  assign io_bus.disp_href   = r_href;
  assign io_bus.disp_vref   = r_vref;
  assign io_bus.hsync       = r_hsync;
  assign io_bus.vsync       = r_vsync;
  assign io_bus.rgb         = r_rgb;
  assign io_bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_disparity_vga_out.sv
// Scoreboard bench for disparity_vga_out with a shrunken raster so several
// whole frames fit in a short run. The reference model works from the linear
// pixel index since reset and plain division/modulo.
module tb_disparity_vga_out;
  localparam int IMG_W = 5, IMG_H = 3, SCALE = 3, GAIN = 16;
  localparam int H_ACTIVE = 28, H_FP = 3, H_SYNC = 5, H_BP = 4;
  localparam int V_ACTIVE = 16, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam int RST_POS = HT * 5 + 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  disparity_vga_out_if vif();

  disparity_vga_out #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .GAIN(GAIN),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .io_bus(vif)
  );

  // Disparity map memory with combinational readback.
  logic [7:0] mem [IMG_W*IMG_H];
  always_comb begin
    if (vif.disp_href < 10'(IMG_W) && vif.disp_vref < 10'(IMG_H))
      vif.disp_data = mem[int'(vif.disp_vref) * IMG_W + int'(vif.disp_href)];
    else
      vif.disp_data = 8'h00;
  end

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [9:0] href;
    logic [9:0] vref;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   dut_fs  = 0;
  int   mdl_fs  = 0;
  bit   started = 1'b0;

  function automatic logic [7:0] gray(input int d);
    int v;
    v = d * GAIN;
    if (v > 255) v = 255;
    return 8'(((v >> 5) << 5) | ((v >> 5) << 2) | (v >> 6));
  endfunction

  function automatic logic [9:0] addr_of(input int pos, input int act, input int lim);
    int a;
    a = (pos < act) ? pos : act;
    a = a / SCALE;
    if (a > lim - 1) a = lim - 1;
    return 10'(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  // Monitor: one expected record per clock edge, compared 1 time unit later.
  always @(posedge clk) begin
    if (started) begin
      #1;
      if (vif.frame_start === 1'b1) dut_fs++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL queue_underflow @%0t: got empty scoreboard, expected a record", $time);
      end else begin
        mon_e = q.pop_front();
        chk("rgb",         32'(vif.rgb),         32'(mon_e.rgb));
        chk("hsync",       32'(vif.hsync),       32'(mon_e.hs));
        chk("vsync",       32'(vif.vsync),       32'(mon_e.vs));
        chk("frame_start", 32'(vif.frame_start), 32'(mon_e.fs));
        chk("disp_href",   32'(vif.disp_href),   32'(mon_e.href));
        chk("disp_vref",   32'(vif.disp_vref),   32'(mon_e.vref));
      end
    end
  end

  // Driver and reference model.
  initial begin : driver
    int   p;
    int   h;
    int   v;
    bit   fv;
    bit   rst_done;
    exp_t cur;
    bit   idle_plan [0:9];

    idle_plan = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    p = 0;
    fv = 1'b0;
    rst_done = 1'b0;
    vif.pix_en = 1'b0;
    vif.disp_idle = 1'b0;
    for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = 8'($urandom_range(0, 31));
    mem[0] = 8'd0;
    mem[1] = 8'd1;
    mem[2] = 8'd14;
    mem[3] = 8'd20;
    cur = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, fs: 1'b0, href: 10'd0, vref: 10'd0};

    for (int c = 0; c < 60000 && mdl_fs < 7; c++) begin
      @(negedge clk);
      // Reset: initial 4 clocks, and one clock mid-frame after the 4th frame start.
      reset = (c < 4) ? 1'b1 : 1'b0;
      if (!rst_done && mdl_fs == 4 && p == RST_POS) begin
        reset = 1'b1;
        rst_done = 1'b1;
      end
      // Pixel strobe: every 4th clock for the first two frames, random after.
      if (mdl_fs < 2) vif.pix_en = (c % 4 == 3) ? 1'b1 : 1'b0;
      else vif.pix_en = ($urandom_range(0, 4) < 2) ? 1'b1 : 1'b0;
      // Idle flag: planned value on the last line, opposite value mid-frame.
      if (p >= FRAME - HT) vif.disp_idle = idle_plan[mdl_fs + 1];
      else if (p == FRAME / 2) vif.disp_idle = ~idle_plan[mdl_fs];
      // Fresh map contents during vertical blanking of later frames.
      if (mdl_fs >= 2 && p == HT * V_ACTIVE)
        for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = 8'($urandom_range(0, 31));

      if (reset) begin
        p = 0;
        fv = 1'b0;
        cur = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, fs: 1'b0, href: 10'd0, vref: 10'd0};
      end else begin
        cur.fs = 1'b0;
        if (vif.pix_en) begin
          h = p % HT;
          v = p / HT;
          if (fv && h < H_ACTIVE && v < V_ACTIVE && h < IMG_W * SCALE && v < IMG_H * SCALE)
            cur.rgb = gray(int'(mem[(v / SCALE) * IMG_W + h / SCALE]));
          else
            cur.rgb = 8'h00;
          cur.hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
          cur.vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
          p = (p + 1) % FRAME;
          if (p == 0) begin
            fv = vif.disp_idle;
            cur.fs = 1'b1;
            mdl_fs++;
          end
        end
      end
      cur.href = addr_of(p % HT, H_ACTIVE, IMG_W);
      cur.vref = addr_of(p / HT, V_ACTIVE, IMG_H);
      q.push_back(cur);
      started = 1'b1;
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    chk("frame_start_count", 32'(dut_fs), 32'(mdl_fs));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
